// File: rtl/data_ram_responder.sv
// Word-organised data RAM with a fixed wait-state responder FSM.
// One access in flight; ready/error/read data are registered.
module data_ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_en,
  input  logic        ram_write_en,
  input  logic [3:0]  ram_write_sel,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_write_data,
  output logic [31:0] ram_read_data,
  output logic        ram_ready,
  output logic        ram_addr_error,
  output logic        ram_busy
);

  localparam int          DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic        req_we_q;
  logic [3:0]  req_sel_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;

  logic [31:0] rdata_q;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic capture;
  logic access;

  logic                  acc_we;
  logic [3:0]            acc_sel;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  in_range;
  logic                  mem_we;
  logic                  rd_load;
  logic                  unused_addr;

  logic [31:0] mem_q [0:DEPTH-1];

  // State and wait counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the zero-wait build accesses straight from IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ram_en) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = WAIT_LD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Access operands and registered-output next values
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we    = ram_write_en;
      acc_sel   = ram_write_sel;
      acc_addr  = ram_addr;
      acc_wdata = ram_write_data;
    end else begin
      acc_we    = req_we_q;
      acc_sel   = req_sel_q;
      acc_addr  = req_addr_q;
      acc_wdata = req_wdata_q;
    end
    acc_idx  = acc_addr[ADDR_WIDTH+1:2];
    in_range = (acc_addr[31:ADDR_WIDTH+2] == '0);
    mem_we   = access & acc_we & in_range & rst;
    rd_load  = access & ~acc_we;
    ready_d  = access;
    err_d    = access & ~in_range;
    busy_d   = (state_d != S_IDLE);
  end

  assign unused_addr = ^acc_addr[1:0];

  // Request capture at acceptance
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_we_q    <= 1'b0;
      req_sel_q   <= 4'd0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
    end else if (capture) begin
      req_we_q    <= ram_write_en;
      req_sel_q   <= ram_write_sel;
      req_addr_q  <= ram_addr;
      req_wdata_q <= ram_write_data;
    end
  end

  // Registered response outputs; read data only moves on reads
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      if (rd_load) begin
        rdata_q <= in_range ? mem_q[acc_idx] : 32'd0;
      end
    end
  end

  // Byte-lane memory write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_sel[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign ram_read_data  = rdata_q;
  assign ram_ready      = ready_q;
  assign ram_addr_error = err_q;
  assign ram_busy       = busy_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder.
// Two builds: WAIT_CYCLES=2 (a_*) and WAIT_CYCLES=0 (b_*).
module tb_data_ram_responder;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, a_en, a_we;
  logic [3:0]  a_sel;
  logic [31:0] a_addr, a_wd, a_rd;
  logic        a_ready, a_err, a_busy;

  logic        rst_b, b_en, b_we;
  logic [3:0]  b_sel;
  logic [31:0] b_addr, b_wd, b_rd;
  logic        b_ready, b_err, b_busy;

  exp_t qa[$];
  exp_t qb[$];
  int n_chk  = 0;
  int n_fail = 0;

  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst_a), .ram_en(a_en),
    .ram_write_en(a_we), .ram_write_sel(a_sel),
    .ram_addr(a_addr), .ram_write_data(a_wd),
    .ram_read_data(a_rd), .ram_ready(a_ready),
    .ram_addr_error(a_err), .ram_busy(a_busy)
  );

  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst_b), .ram_en(b_en),
    .ram_write_en(b_we), .ram_write_sel(b_sel),
    .ram_addr(b_addr), .ram_write_data(b_wd),
    .ram_read_data(b_rd), .ram_ready(b_ready),
    .ram_addr_error(b_err), .ram_busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop expected response on every ready pulse
  always @(negedge clk) begin
    exp_t e;
    if (a_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_rdata", a_rd, e.rd);
        chk("a_err", {31'd0, a_err}, {31'd0, e.err});
      end
    end else begin
      chk("a_err_idle", {31'd0, a_err}, 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_rdata", b_rd, e.rd);
        chk("b_err", {31'd0, b_err}, {31'd0, e.err});
      end
    end
  end

  task automatic a_access(input logic we, input logic [3:0] sel,
                          input logic [31:0] addr,
                          input logic [31:0] wd,
                          input logic [31:0] exp_rd,
                          input logic exp_err);
    int n;
    logic busy_ok;
    qa.push_back('{exp_rd, exp_err});
    @(negedge clk);
    a_we = we; a_sel = sel; a_addr = addr; a_wd = wd;
    a_en = 1'b1;
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!a_busy) busy_ok = 1'b0;
    end while (!a_ready && n < 50);
    a_en = 1'b0;
    chk("a_latency", n, 32'd3);
    chk("a_busy_window", {31'd0, busy_ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, gap;
    rst_a = 1'b0; a_en = 1'b0; a_we = 1'b0;
    a_sel = 4'd0; a_addr = 32'd0; a_wd = 32'd0;
    rst_b = 1'b0; b_en = 1'b0; b_we = 1'b0;
    b_sel = 4'd0; b_addr = 32'd0; b_wd = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_a_rdata", a_rd, 32'd0);
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_b_rdata", b_rd, 32'd0);
    chk("rst_b_busy", {31'd0, b_busy}, 32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Word write then read
    a_access(1, 4'hF, 32'h40, 32'hDEADBEEF, 32'h0, 0);
    a_access(0, 4'hF, 32'h40, 32'h0, 32'hDEADBEEF, 0);
    // Byte lanes, read with sel ignored
    a_access(1, 4'hF, 32'h80, 32'h11223344, 32'hDEADBEEF, 0);
    a_access(1, 4'h5, 32'h80, 32'hAABBCCDD, 32'hDEADBEEF, 0);
    a_access(0, 4'h0, 32'h80, 32'h0, 32'h11BB33DD, 0);
    // Out of range
    a_access(1, 4'hF, 32'h0, 32'hCAFEF00D, 32'h11BB33DD, 0);
    a_access(1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h11BB33DD, 1);
    a_access(0, 4'hF, 32'h0, 32'h0, 32'hCAFEF00D, 0);
    a_access(0, 4'hF, 32'h1000, 32'h0, 32'h0, 1);
    // sel=0000 write, then unaligned read
    a_access(1, 4'h0, 32'h40, 32'h0, 32'h0, 0);
    a_access(0, 4'hF, 32'h43, 32'h0, 32'hDEADBEEF, 0);

    // Reset mid-wait aborts the write
    a_access(1, 4'hF, 32'h10, 32'h55AA55AA, 32'hDEADBEEF, 0);
    @(negedge clk);
    a_we = 1'b1; a_sel = 4'hF;
    a_addr = 32'h10; a_wd = 32'h12345678;
    a_en = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    a_en = 1'b0;
    @(negedge clk);
    chk("mrst_rdata", a_rd, 32'd0);
    chk("mrst_ready", {31'd0, a_ready}, 32'd0);
    chk("mrst_err", {31'd0, a_err}, 32'd0);
    chk("mrst_busy", {31'd0, a_busy}, 32'd0);
    rst_a = 1'b1;
    a_access(0, 4'hF, 32'h10, 32'h0, 32'h55AA55AA, 0);

    // Held request: two reads with ram_en never dropped
    qa.push_back('{32'hDEADBEEF, 1'b0});
    qa.push_back('{32'hDEADBEEF, 1'b0});
    @(negedge clk);
    a_we = 1'b0; a_sel = 4'hF; a_addr = 32'h40;
    a_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
      while (!a_ready && n < 50);
    chk("held_first_latency", n, 32'd3);
    gap = 0;
    do begin @(negedge clk); gap++; end
      while (!a_ready && gap < 50);
    a_en = 1'b0;
    chk("held_gap", gap, 32'd4);

    // Zero-wait build: write then read, ram_en held
    qb.push_back('{32'h0, 1'b0});
    qb.push_back('{32'h0BADF00D, 1'b0});
    @(negedge clk);
    b_we = 1'b1; b_sel = 4'hF;
    b_addr = 32'h8; b_wd = 32'h0BADF00D;
    b_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
      while (!b_ready && n < 50);
    chk("b_latency", n, 32'd1);
    chk("b_busy_resp", {31'd0, b_busy}, 32'd1);
    b_we = 1'b0;
    gap = 0;
    do begin @(negedge clk); gap++; end
      while (!b_ready && gap < 50);
    b_en = 1'b0;
    chk("b_gap", gap, 32'd2);

    repeat (4) @(negedge clk);
    chk("a_queue_empty", qa.size(), 32'd0);
    chk("b_queue_empty", qb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_ram_responder.md
DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address bits (memory depth 2^ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, added wait states per access, legal range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low (RST_ENABLE = 0).
REQ-005 SHALL have port ram_en  input  1  access request from the pipeline; held high by the requester until ram_ready is seen.
REQ-006 SHALL have port ram_write_en  input  1  1 = write, 0 = read.
REQ-007 SHALL have port ram_write_sel  input  4  byte-lane enables for writes; bit i selects bits 8i+7:8i.
REQ-008 SHALL have port ram_addr  input  32  byte address.
REQ-009 SHALL have port ram_write_data  input  32  write data, lane-aligned.
REQ-010 SHALL have port ram_read_data  output  32  registered read result.
REQ-011 SHALL have port ram_ready  output  1  registered one-cycle completion pulse.
REQ-012 SHALL have port ram_addr_error  output  1  registered; qualifies ram_ready, high when the address is out of range.
REQ-013 SHALL have port ram_busy  output  1  high whenever state is not IDLE; the pipeline uses it as a stall request.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 IDLE: when ram_en=1 at an edge, SHALL capture write_en, write_sel, addr and write_data into request registers, load wait counter = WAIT_CYCLES, and go to WAIT; if WAIT_CYCLES=0, SHALL perform the access at that same edge and go directly to RESP.
REQ-016 WAIT: at each edge, if counter==1, SHALL perform the access and go to RESP; otherwise SHALL decrement the counter.
REQ-017 RESP: SHALL hold ram_ready=1 for exactly this one cycle, SHALL not sample ram_en, and SHALL return to IDLE at the next edge.
REQ-018 Latency: for a request first sampled at the end of cycle 0, ram_ready SHALL be high in cycle WAIT_CYCLES+1; back-to-back requests SHALL be accepted no earlier than cycle WAIT_CYCLES+2.
REQ-019 Inputs SHALL be ignored in WAIT and RESP; only the captured request registers are used for the access.
REQ-020 Word index SHALL be ram_addr[ADDR_WIDTH+1:2]; ram_addr[1:0] SHALL be ignored.
REQ-021 Write: SHALL update only the lanes whose ram_write_sel bit is 1; ram_write_sel=0000 SHALL complete normally with no memory change; ram_read_data SHALL hold its previous value.
REQ-022 Read: SHALL return the full 32-bit word regardless of ram_write_sel and load ram_read_data at the access edge.
REQ-023 Range check: if ram_addr[31:ADDR_WIDTH+2] is nonzero, the access SHALL set ram_addr_error=1 during RESP, suppress any write, and load ram_read_data with 0 on a read.
REQ-024 ram_addr_error SHALL be 0 in every state except RESP of an out-of-range access.
REQ-025 Memory contents SHALL be uninitialised and are not affected by reset.

Reset
REQ-026 While rst=0 at an edge, SHALL set state to IDLE, counter to 0, and ram_ready, ram_addr_error and ram_busy to 0, and ram_read_data to 0x00000000.
REQ-027 Reset in WAIT SHALL abort the request; a pending write SHALL NOT be committed.
REQ-028 Reset in RESP SHALL not undo an already committed write.
REQ-029 The first edge with rst=1 SHALL leave the block in IDLE, able to sample ram_en.

Verification
REQ-030 Word write then read, WAIT_CYCLES=2: write 0xDEADBEEF to 0x40 with sel=1111, then read 0x40 -> ram_ready high in cycle 3 of each access; the read returns 0xDEADBEEF; ram_busy high in cycles 1-3.
REQ-031 Byte lanes: preload 0x11223344 at 0x80, then write 0xAABBCCDD with sel=0101 -> reading 0x80 returns 0x11BB33DD.
REQ-032 Zero wait: WAIT_CYCLES=0, read request in cycle 0 -> ram_ready in cycle 1; next request accepted in cycle 2.
REQ-033 Out of range, ADDR_WIDTH=10: write to 0x00001000 -> ram_addr_error=1 with ram_ready; a later read of 0x0 still returns the prior value; a read of 0x00001000 returns 0 with error=1.
REQ-034 Reset mid-wait: start a write of 0x12345678 to 0x10 and drop rst in cycle 1 -> all outputs 0 next cycle; a later read of 0x10 returns the old contents.
REQ-035 Held request: keep ram_en=1 continuously through two requests -> exactly one ram_ready pulse per access, separated by WAIT_CYCLES+2 cycles.
